// File: rtl/ysyx_22040759_mem_arbiter_if.sv
// Bundle of the two requester ports (IF, MEM) and the AXI-bridge port of the memory arbiter.
// The arbiter uses the slave modport; the pipeline/bridge side (or a bench) uses master.
// Widths: AW address bits, DW data bits, DW/8 strobe bits.
interface ysyx_22040759_mem_arbiter_if #(
    parameter int AW = 64,
    parameter int DW = 64
);
    logic              if_req;
    logic [AW-1:0]     if_addr;
    logic              if_ready;
    logic [DW-1:0]     if_rdata;
    logic              if_stall;

    logic              mem_req;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW/8-1:0]   mem_wstrb;
    logic              mem_ready;
    logic [DW-1:0]     mem_rdata;
    logic              mem_stall;

    logic              bus_valid;
    logic              bus_we;
    logic [AW-1:0]     bus_addr;
    logic [DW-1:0]     bus_wdata;
    logic [DW/8-1:0]   bus_wstrb;
    logic              bus_ready;
    logic [DW-1:0]     bus_rdata;

    modport slave (
        input  if_req, if_addr,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  bus_ready, bus_rdata,
        output if_ready, if_rdata, if_stall,
        output mem_ready, mem_rdata, mem_stall,
        output bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
    );

    modport master (
        output if_req, if_addr,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output bus_ready, bus_rdata,
        input  if_ready, if_rdata, if_stall,
        input  mem_ready, mem_rdata, mem_stall,
        input  bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb
    );
endinterface

// File: rtl/ysyx_22040759_mem_arbiter.sv
// Two-requester (IF / MEM) arbiter serialising transactions onto the single AXI-bridge port.
// Latency: req in IDLE -> bus_valid next cycle; bus_ready in cycle k -> ready pulse in k+1, IDLE in k+2.
// Backpressure: a losing or late request simply waits at level until the next IDLE; stalls are
// combinational (req & ~ready). Optional macro YSYX_22040759_ARB_RR_EN selects round-robin ties,
// otherwise MEM wins every tie.
module ysyx_22040759_mem_arbiter #(
    parameter int AW = 64,
    parameter int DW = 64
) (
    input  logic clk,
    input  logic rst,
    ysyx_22040759_mem_arbiter_if.slave arb
);
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // grant / last_grant encoding: 0 = IF, 1 = MEM
    state_t          state;
    logic            grant;
    logic            last_grant;
    logic            pick_mem;

    logic            bus_valid_q;
    logic            bus_we_q;
    logic [AW-1:0]   bus_addr_q;
    logic [DW-1:0]   bus_wdata_q;
    logic [SW-1:0]   bus_wstrb_q;
    logic            if_ready_q;
    logic            mem_ready_q;
    logic [DW-1:0]   if_rdata_q;
    logic [DW-1:0]   mem_rdata_q;

`ifdef YSYX_22040759_ARB_RR_EN
    // On a tie the requester that was not served last wins; a lone requester always wins.
    assign pick_mem = arb.mem_req & (~arb.if_req | ~last_grant);
`else
    // Fixed priority: MEM wins whenever it asks.
    assign pick_mem = arb.mem_req;
    // last_grant is still tracked so a round-robin build and this one share the same state;
    // it is intentionally not consumed here.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
`endif

    // Transaction FSM with all outputs registered; the rdata registers double as the return buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            grant       <= 1'b0;
            last_grant  <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (arb.if_req | arb.mem_req) begin
                        state       <= BUSY;
                        bus_valid_q <= 1'b1;
                        grant       <= pick_mem;
                        if (pick_mem) begin
                            bus_we_q    <= arb.mem_we;
                            bus_addr_q  <= arb.mem_addr;
                            bus_wdata_q <= arb.mem_wdata;
                            bus_wstrb_q <= arb.mem_we ? arb.mem_wstrb : '0;
                        end else begin
                            bus_we_q    <= 1'b0;
                            bus_addr_q  <= arb.if_addr;
                            bus_wdata_q <= '0;
                            bus_wstrb_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (arb.bus_ready) begin
                        state       <= DONE;
                        bus_valid_q <= 1'b0;
                        if (grant) begin
                            mem_ready_q <= 1'b1;
                            // stores return no data
                            mem_rdata_q <= bus_we_q ? '0 : arb.bus_rdata;
                        end else begin
                            if_ready_q  <= 1'b1;
                            if_rdata_q  <= arb.bus_rdata;
                        end
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    last_grant  <= grant;
                    if_ready_q  <= 1'b0;
                    mem_ready_q <= 1'b0;
                    if_rdata_q  <= '0;
                    mem_rdata_q <= '0;
                end
                default: begin
                    state       <= IDLE;
                    bus_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign arb.bus_valid = bus_valid_q;
    assign arb.bus_we    = bus_we_q;
    assign arb.bus_addr  = bus_addr_q;
    assign arb.bus_wdata = bus_wdata_q;
    assign arb.bus_wstrb = bus_wstrb_q;
    assign arb.if_ready  = if_ready_q;
    assign arb.if_rdata  = if_rdata_q;
    assign arb.mem_ready = mem_ready_q;
    assign arb.mem_rdata = mem_rdata_q;
    assign arb.if_stall  = arb.if_req  & ~if_ready_q;
    assign arb.mem_stall = arb.mem_req & ~mem_ready_q;
endmodule

// File: tb/tb_ysyx_22040759_mem_arbiter.sv
// Directed bench for the IF/MEM memory arbiter; cycle n is the interval after the n-th rising edge.
// Inputs change 1 time unit after a rising edge; outputs are checked in the same interval.
// Tie-order expectations follow YSYX_22040759_ARB_RR_EN when the bench is built with it.
module tb_ysyx_22040759_mem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;

    ysyx_22040759_mem_arbiter_if #(.AW(64), .DW(64)) arb ();

    ysyx_22040759_mem_arbiter #(.AW(64), .DW(64)) dut (
        .clk (clk),
        .rst (rst),
        .arb (arb)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, ".bus_valid"}, {63'd0, arb.bus_valid}, 64'd0);
        chk({tag, ".if_ready"},  {63'd0, arb.if_ready},  64'd0);
        chk({tag, ".mem_ready"}, {63'd0, arb.mem_ready}, 64'd0);
        chk({tag, ".if_rdata"},  arb.if_rdata,  64'd0);
        chk({tag, ".mem_rdata"}, arb.mem_rdata, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_mem [3];
`ifdef YSYX_22040759_ARB_RR_EN
        exp_mem = '{1'b1, 1'b0, 1'b1};
`else
        exp_mem = '{1'b1, 1'b1, 1'b1};
`endif
        arb.if_req = 0; arb.if_addr = 0;
        arb.mem_req = 0; arb.mem_we = 0; arb.mem_addr = 0; arb.mem_wdata = 0; arb.mem_wstrb = 0;
        arb.bus_ready = 0; arb.bus_rdata = 0;

        // ---- reset state
        tick(); tick(); tick();
        chk_idle_outputs("reset");
        chk("reset.bus_addr",  arb.bus_addr, 64'd0);
        chk("reset.bus_wdata", arb.bus_wdata, 64'd0);
        chk("reset.bus_wstrb", {56'd0, arb.bus_wstrb}, 64'd0);
        chk("reset.bus_we",    {63'd0, arb.bus_we}, 64'd0);
        rst = 0;

        // ---- single fetch, bridge answers in cycle 3
        tick();
        arb.if_req = 1; arb.if_addr = 64'h8000_0000; #1;
        chk("fetch.c0.if_stall", {63'd0, arb.if_stall}, 64'd1);
        tick();
        chk("fetch.c1.bus_valid", {63'd0, arb.bus_valid}, 64'd1);
        chk("fetch.c1.bus_addr",  arb.bus_addr, 64'h8000_0000);
        chk("fetch.c1.bus_we",    {63'd0, arb.bus_we}, 64'd0);
        chk("fetch.c1.bus_wstrb", {56'd0, arb.bus_wstrb}, 64'd0);
        chk("fetch.c1.bus_wdata", arb.bus_wdata, 64'd0);
        tick();
        chk("fetch.c2.bus_valid", {63'd0, arb.bus_valid}, 64'd1);
        chk("fetch.c2.if_stall",  {63'd0, arb.if_stall}, 64'd1);
        tick();
        chk("fetch.c3.bus_valid", {63'd0, arb.bus_valid}, 64'd1);
        arb.bus_ready = 1; arb.bus_rdata = 64'h0000_0013_0000_0093;
        tick();
        arb.bus_ready = 0; arb.bus_rdata = 0; #1;
        chk("fetch.c4.if_ready",  {63'd0, arb.if_ready}, 64'd1);
        chk("fetch.c4.if_rdata",  arb.if_rdata, 64'h0000_0013_0000_0093);
        chk("fetch.c4.if_stall",  {63'd0, arb.if_stall}, 64'd0);
        chk("fetch.c4.mem_ready", {63'd0, arb.mem_ready}, 64'd0);
        chk("fetch.c4.bus_valid", {63'd0, arb.bus_valid}, 64'd0);
        tick();
        arb.if_req = 0;
        chk("fetch.c5.if_ready", {63'd0, arb.if_ready}, 64'd1 ^ 64'd1);
        chk("fetch.c5.if_rdata", arb.if_rdata, 64'd0);

        // ---- store, zero-latency bridge returning junk data
        arb.mem_req = 1; arb.mem_we = 1; arb.mem_addr = 64'h8000_1000;
        arb.mem_wdata = 64'hDEAD_BEEF_CAFE_F00D; arb.mem_wstrb = 8'h0F;
        tick();
        chk("store.bus_valid", {63'd0, arb.bus_valid}, 64'd1);
        chk("store.bus_we",    {63'd0, arb.bus_we}, 64'd1);
        chk("store.bus_addr",  arb.bus_addr, 64'h8000_1000);
        chk("store.bus_wdata", arb.bus_wdata, 64'hDEAD_BEEF_CAFE_F00D);
        chk("store.bus_wstrb", {56'd0, arb.bus_wstrb}, 64'h0F);
        arb.bus_ready = 1; arb.bus_rdata = 64'h1234_5678_9ABC_DEF0;
        tick();
        arb.bus_ready = 0;
        chk("store.mem_ready", {63'd0, arb.mem_ready}, 64'd1);
        chk("store.mem_rdata", arb.mem_rdata, 64'd0);
        chk("store.if_ready",  {63'd0, arb.if_ready}, 64'd0);
        tick();
        arb.mem_req = 0; arb.mem_we = 0;
        chk("store.after.mem_ready", {63'd0, arb.mem_ready}, 64'd0);

        // ---- load with stray strobes: strobes must be forced to zero
        arb.mem_req = 1; arb.mem_we = 0; arb.mem_addr = 64'h8000_2008; arb.mem_wstrb = 8'hFF;
        tick();
        chk("load.bus_we",    {63'd0, arb.bus_we}, 64'd0);
        chk("load.bus_wstrb", {56'd0, arb.bus_wstrb}, 64'd0);
        chk("load.bus_addr",  arb.bus_addr, 64'h8000_2008);
        tick();
        arb.bus_ready = 1; arb.bus_rdata = 64'h0123_4567_89AB_CDEF;
        tick();
        arb.bus_ready = 0;
        chk("load.mem_ready", {63'd0, arb.mem_ready}, 64'd1);
        chk("load.mem_rdata", arb.mem_rdata, 64'h0123_4567_89AB_CDEF);
        tick();
        arb.mem_req = 0; arb.mem_wstrb = 0;

        // ---- spurious bus_ready in IDLE
        tick();
        arb.bus_ready = 1; arb.bus_rdata = 64'hFFFF_0000_FFFF_0000;
        tick();
        arb.bus_ready = 0; arb.bus_rdata = 0;
        chk_idle_outputs("spurious.c1");
        tick();
        chk_idle_outputs("spurious.c2");

        // ---- reset in BUSY cycle 2
        arb.if_req = 1; arb.if_addr = 64'h8000_0040;
        tick();
        chk("rstmid.c1.bus_valid", {63'd0, arb.bus_valid}, 64'd1);
        tick();
        rst = 1;
        tick();
        rst = 0; arb.if_req = 0;
        chk_idle_outputs("rstmid.c3");
        chk("rstmid.c3.bus_addr", arb.bus_addr, 64'd0);
        arb.bus_ready = 1; arb.bus_rdata = 64'h5555;
        tick();
        arb.bus_ready = 0;
        chk_idle_outputs("rstmid.c4");

        // ---- fresh fetch after reset
        arb.if_req = 1; arb.if_addr = 64'h8000_0080;
        tick();
        chk("fresh.bus_valid", {63'd0, arb.bus_valid}, 64'd1);
        chk("fresh.bus_addr",  arb.bus_addr, 64'h8000_0080);
        arb.bus_ready = 1; arb.bus_rdata = 64'hAAAA_BBBB;
        tick();
        arb.bus_ready = 0;
        chk("fresh.if_ready", {63'd0, arb.if_ready}, 64'd1);
        chk("fresh.if_rdata", arb.if_rdata, 64'hAAAA_BBBB);
        tick();
        arb.if_req = 0;

        // ---- tie, MEM dropped after its ready: MEM ready cycle 2, IF ready cycle 5
        arb.if_req = 1; arb.if_addr = 64'h8000_0100;
        arb.mem_req = 1; arb.mem_we = 0; arb.mem_addr = 64'h8000_3000;
        tick();
        chk("tie.c1.bus_addr", arb.bus_addr, 64'h8000_3000);
        arb.bus_ready = 1; arb.bus_rdata = 64'h1111;
        tick();
        arb.bus_ready = 0; #1;
        chk("tie.c2.mem_ready", {63'd0, arb.mem_ready}, 64'd1);
        chk("tie.c2.mem_rdata", arb.mem_rdata, 64'h1111);
        chk("tie.c2.if_ready",  {63'd0, arb.if_ready}, 64'd0);
        chk("tie.c2.if_stall",  {63'd0, arb.if_stall}, 64'd1);
        chk("tie.c2.mem_stall", {63'd0, arb.mem_stall}, 64'd0);
        tick();
        arb.mem_req = 0; #1;
        chk("tie.c3.bus_valid", {63'd0, arb.bus_valid}, 64'd0);
        chk("tie.c3.if_stall",  {63'd0, arb.if_stall}, 64'd1);
        tick();
        chk("tie.c4.bus_addr", arb.bus_addr, 64'h8000_0100);
        chk("tie.c4.bus_we",   {63'd0, arb.bus_we}, 64'd0);
        arb.bus_ready = 1; arb.bus_rdata = 64'h2222;
        tick();
        arb.bus_ready = 0;
        chk("tie.c5.if_ready", {63'd0, arb.if_ready}, 64'd1);
        chk("tie.c5.if_rdata", arb.if_rdata, 64'h2222);
        tick();
        arb.if_req = 0;

        // ---- both held across three transactions (last served: IF)
        arb.if_req = 1; arb.if_addr = 64'h8000_0200;
        arb.mem_req = 1; arb.mem_we = 0; arb.mem_addr = 64'h8000_4000;
        for (int t = 0; t < 3; t++) begin
            tick();
            chk($sformatf("hold.t%0d.bus_addr", t), arb.bus_addr,
                exp_mem[t] ? 64'h8000_4000 : 64'h8000_0200);
            arb.bus_ready = 1; arb.bus_rdata = 64'h3000 + 64'(t);
            tick();
            arb.bus_ready = 0;
            chk($sformatf("hold.t%0d.mem_ready", t), {63'd0, arb.mem_ready}, {63'd0, exp_mem[t]});
            chk($sformatf("hold.t%0d.if_ready", t),  {63'd0, arb.if_ready},  {63'd0, ~exp_mem[t]});
            tick();
        end
        arb.if_req = 0; arb.mem_req = 0;
        tick();
        tick();
        chk_idle_outputs("final");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/ysyx_22040759_mem_arbiter.md
# ysyx_22040759_mem_arbiter

Two-requester memory arbiter for the ysyx_22040759 five-stage core. It shares the single memory port of the AXI bridge between instruction fetch (IF) and the MEM-stage load/store unit. It serialises one transaction at a time and returns data to the winning requester. It also drives per-requester stall signals that the pipeline hazard/stall logic ORs into its PC-write and IF/ID-write holds.

## Interface
- AW, 64, address width
- DW, 64, data width; strobe width is DW/8

- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- if_req  in  1  fetch request, level, held until if_ready
- if_addr  in  AW  fetch address
- if_ready  out  1  one-cycle completion pulse to IF
- if_rdata  out  DW  fetch data, valid while if_ready=1
- if_stall  out  1  if_req & ~if_ready
- mem_req  in  1  load/store request, level, held until mem_ready
- mem_we  in  1  1=store, 0=load
- mem_addr  in  AW  data address
- mem_wdata  in  DW  store data
- mem_wstrb  in  DW/8  store byte strobes
- mem_ready  out  1  one-cycle completion pulse to MEM
- mem_rdata  out  DW  load data, valid while mem_ready=1
- mem_stall  out  1  mem_req & ~mem_ready
- bus_valid  out  1  request to AXI bridge
- bus_we  out  1  write select
- bus_addr  out  AW  latched address
- bus_wdata  out  DW  latched write data (0 for IF)
- bus_wstrb  out  DW/8  latched strobes (0 for IF or load)
- bus_ready  in  1  bridge completion, single cycle
- bus_rdata  in  DW  read data, valid with bus_ready

## Operation
- FSM states: IDLE, BUSY, DONE. Registers: grant (IF/MEM), last_grant, latched bus fields, rdata buffer.
- IDLE: if any req, choose a winner, latch its addr/we/wdata/wstrb, set grant, and go to BUSY. Without a req, stay in IDLE.
- BUSY: bus_valid=1 with latched fields held stable. On bus_ready, capture bus_rdata into the buffer and go to DONE. bus_ready outside BUSY is ignored.
- DONE: pulse the granted requester's ready with the buffered rdata, update last_grant=grant, then go to IDLE. The other ready stays 0.
- Requester contract: req stays high with stable fields until ready. A requester presents its next request (or drops req) on the cycle after ready. If req drops while granted, that is a protocol violation. The arbiter still completes the transaction and pulses ready.
- IF requests force bus_we=0, bus_wdata=0, bus_wstrb=0. MEM loads force bus_wstrb=0.
- rdata outputs are 0 when the corresponding ready is 0.

## Timing
- Reset: state=IDLE, grant=IF, last_grant=IF, and every output 0, including bus_* and rdata buffers. If reset lands mid-transaction, the transaction is abandoned and bus_valid is 0 the cycle after rst is sampled. The bridge is reset by the same rst.
- Latency: req seen in IDLE at cycle 0 → bus_valid from cycle 1. bus_ready in cycle k≥1 → ready pulse in cycle k+1 → IDLE in cycle k+2.
- Minimum req-to-ready is 2 cycles. Maximum throughput is one transaction per 3 cycles plus bridge latency.
- Stall outputs are combinational from req and ready. They deassert exactly in the ready cycle.
- Simultaneous requests are resolved per Configuration. A request arriving while BUSY/DONE waits. It is evaluated in the next IDLE.

## Configuration
- YSYX_22040759_ARB_RR_EN defined: round-robin on simultaneous requests. The winner is the requester that is not last_grant. After reset the first tie goes to MEM. A single requester always wins regardless of last_grant.
- Not defined: fixed priority, MEM over IF on every tie. last_grant is still maintained but unused.

## Test plan
- Single fetch: if_req=1, if_addr=0x8000_0000; bridge bus_ready at cycle 3, bus_rdata=0x0000_0013_0000_0093 → bus_valid cycles 1–3 with addr 0x8000_0000, we=0, wstrb=0. if_ready=1 with that data in cycle 4. if_stall=1 cycles 0–3.
- Store: mem_req=1, mem_we=1, addr 0x8000_1000, wdata 0xDEAD_BEEF_CAFE_F00D, wstrb 0x0F → bus fields match exactly. mem_ready pulses once, and mem_rdata=0 on that pulse.
- Tie, macro undefined: both req at cycle 0 with zero-latency bridge → MEM served first (ready cycle 2). IF is granted in the following IDLE (ready cycle 5).
- Tie, macro defined: both held across three transactions → order is MEM, IF, MEM.
- Reset mid-transaction: rst during BUSY cycle 2 → cycle 3 has bus_valid=0, no ready pulse, state IDLE. A fresh if_req then completes normally.
- Spurious bus_ready in IDLE with no req → no ready pulse and no state change.
